ram_master: RTL
===============

Name: ram_master

Overview:
- Initiator-side controller for the single-port synchronous RAM, which has ports WE, address, dataIn and dataOut.
- Accepts burst read/write commands over a valid/ready request channel, streams write data in and read data out, and drives the RAM pins with registered signals.
- Sits between a processor-side datapath and the RAM instance, so the RAM's testbench-style directed stimulus is replaced by real transactions.

Parameters:
- ADDR_WIDTH, 10, RAM address width; the address space wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, RAM word width.
- LEN_WIDTH, 4, burst length field width; a burst is req_len+1 beats, 1..16.
- RD_LAT, 1, RAM read latency in cycles, from ram_address registered to ram_dataOut valid; legal range 1..4.

Ports:
- clk  in  1  single clock; all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  start address.
- req_len  in  LEN_WIDTH  beats minus one.
- wd_valid  in  1  write beat valid.
- wd_ready  out  1  high only in WR.
- wd_data  in  DATA_WIDTH  write beat data.
- rd_valid  out  1  read beat valid; held until rd_ready.
- rd_ready  in  1  read beat accept.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_last  out  1  final beat of the burst, qualified by rd_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on burst completion.
- err_flag  out  1  sticky verify mismatch; tied 0 without the feature.
- err_addr  out  ADDR_WIDTH  address of the first mismatch; tied 0 without the feature.
- ram_we  out  1  to RAM WE, registered.
- ram_address  out  ADDR_WIDTH  to RAM address, registered.
- ram_dataIn  out  DATA_WIDTH  to RAM dataIn, registered.
- ram_dataOut  in  DATA_WIDTH  from RAM dataOut.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state = IDLE.
  - ram_we, rd_valid, rd_last, done, err_flag = 0.
  - ram_address, ram_dataIn, rd_data, err_addr = 0.
  - Reset mid-burst abandons the burst with no completion pulse; ram_we drops the instant rst_n falls.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE:
  - req_valid & req_ready latches addr and len, then goes to WR (req_wr=1) or RD_ISSUE (req_wr=0).
  - Other req_* inputs are ignored outside IDLE.
- WR:
  - wd_ready = 1.
  - On each wd handshake, the next cycle drives ram_we = 1, ram_address = current address, ram_dataIn = wd_data; the address then increments.
  - Back-to-back beats are allowed, 1 beat per cycle.
  - If wd_valid = 0, ram_we = 0 that cycle (bubble).
  - After the last beat's handshake, go to IDLE.
- RD_ISSUE: drive ram_address = current address with ram_we = 0, then go to RD_WAIT.
- RD_WAIT:
  - Count RD_LAT cycles.
  - On the final count edge, capture ram_dataOut into rd_data, set rd_valid = 1, set rd_last if the beat is last, and go to RD_HOLD.
- RD_HOLD:
  - rd_data and rd_valid are stable until rd_ready.
  - On handshake, drop rd_valid and increment the address.
  - Go to RD_ISSUE, or to IDLE if the beat was last.
  - Throughput is 1 beat per RD_LAT+2 cycles when rd_ready is held high.
- Address wrap: ADDR_WIDTH-bit increment, so 1023 -> 0 for the defaults; no error is raised.
- done:
  - Registered; high for the one cycle in which the state is IDLE after the last beat completes.
  - Concurrent with req_ready = 1, so a new command may be accepted in the done cycle.
- req_len = 0 performs exactly one beat.

Optional Feature:
- Macro: RAM_MASTER_WR_VERIFY_EN.
- Defined:
  - Each write beat is followed by a read-back of the same address: one RD_ISSUE, then RD_WAIT.
  - wd_ready is deasserted during the read-back.
  - A mismatch against the written word sets err_flag (sticky until reset) and records err_addr for the first mismatch only.
  - Write throughput becomes 1 beat per RD_LAT+2 cycles.
  - done is delayed until the last read-back compare.
- Undefined: no read-back; err_flag and err_addr are constant 0.

Decomposition:
- Package ram_master_pkg holds:
  - the state enum;
  - default ADDR_WIDTH, DATA_WIDTH and LEN_WIDTH constants;
  - the RD_LAT range constants.
- Sub-module ram_addr_gen, a natural split:
  - load(start, len), step;
  - address output (wrapping), remaining-beat counter, last flag.

Test Plan:
- Single write then single read:
  - write addr 1 = 16'habcc, len 0; then read addr 1.
  - Required: ram_we high for exactly 1 cycle with ram_address=1; rd_data=16'habcc, rd_last=1, one done per burst.
- 4-beat write burst with no bubbles:
  - start addr 1, wd_data = 16'habcc, 16'hbbdd, 16'hccee, 16'h1234.
  - Required: ram_we high on 4 consecutive cycles at addresses 1..4; the 4-beat read-back returns the same sequence, with rd_last only on the 4th beat.
- Wrap-around:
  - write 2 beats at addr 1023 = 16'h568f, 16'h568e.
  - Required: writes land at 1023 then 0; reading 1023 and 0 returns those values.
- Backpressure and bubbles:
  - read burst of 3 with rd_ready low for 5 cycles on beat 2; write burst with wd_valid low for 2 cycles mid-burst.
  - Required: rd_data stable while held; no ram_we during bubbles; beat count exact.
- Reset mid-burst:
  - rst_n low during beat 2 of a 4-beat write.
  - Required: ram_we 0 immediately; no further writes; no done; req_ready=1 after release.
  - Also, with the feature enabled, force a ram_dataOut mismatch at addr 3: err_flag=1 and err_addr=3 persist.

Source files
------------

// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared FSM state type and default sizing for ram_master.
package ram_master_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD} state_e;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF = 4;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/ram_master_if.sv
// ram_master_if: host request/stream channels plus RAM pin bundle of ram_master.
interface ram_master_if import ram_master_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
);
  logic req_valid, req_ready, req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0] req_len;
  logic wd_valid, wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic rd_valid, rd_ready, rd_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic busy, done, err_flag;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic ram_we;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_dataIn, ram_dataOut;
  modport master (
    input req_valid, req_wr, req_addr, req_len, wd_valid, wd_data, rd_ready, ram_dataOut,
    output req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, done, err_flag, err_addr,
           ram_we, ram_address, ram_dataIn
  );
  modport slave (
    output req_valid, req_wr, req_addr, req_len, wd_valid, wd_data, rd_ready, ram_dataOut,
    input req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, done, err_flag, err_addr,
          ram_we, ram_address, ram_dataIn
  );
endinterface

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: burst address generator with wrapping address and remaining-beat count.
module ram_addr_gen #(
  parameter int AW = 10,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] start_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] addr_nxt_o,
  output logic          last_o
);
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  assign addr_nxt_o = addr_q + 1'b1;
  assign addr_o = addr_q;
  assign last_o = rem_q == '0;
  always_comb begin
    addr_d = load_i ? start_i : step_i ? addr_nxt_o : addr_q;
    rem_d = load_i ? len_i : step_i ? rem_q - 1'b1 : rem_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: rtl/ram_master.sv
// ram_master: burst read/write initiator driving a single-port synchronous RAM with registered pins.
// Define RAM_MASTER_WR_VERIFY_EN to read back and compare every written word.
module ram_master import ram_master_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int RD_LAT = RD_LAT_MIN
) (
  input logic          clk,
  input logic          rst_n,
  ram_master_if.master bus
);
`ifdef RAM_MASTER_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic vfy_q, vfy_d;
  logic ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d, err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, done_q, done_d, err_flag_q, err_flag_d;
  logic load, step, last, mismatch;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  assign load = state_q == IDLE && bus.req_valid;
  assign mismatch = bus.ram_dataOut != ram_din_q;
  ram_addr_gen #(.AW(ADDR_WIDTH), .LW(LEN_WIDTH)) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .load_i(load), .step_i(step),
    .start_i(bus.req_addr), .len_i(bus.req_len),
    .addr_o(addr), .addr_nxt_o(addr_nxt), .last_o(last)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vfy_d = vfy_q;
    ram_we_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d = ram_din_q;
    rd_data_d = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d = rd_last_q;
    done_d = 1'b0;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    step = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = bus.req_wr ? WR : RD_ISSUE;
        vfy_d = VERIFY & bus.req_wr;
        ram_addr_d = bus.req_addr;
      end
      WR: if (bus.wd_valid) begin
        ram_we_d = 1'b1;
        ram_addr_d = addr;
        ram_din_d = bus.wd_data;
        step = !vfy_q;
        state_d = vfy_q ? RD_ISSUE : last ? IDLE : WR;
        done_d = !vfy_q && last;
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d = 3'(RD_LAT - 1);
      end
      RD_WAIT: if (cnt_q != '0) begin
        cnt_d = cnt_q - 3'd1;
      end else if (vfy_q) begin
        // read-back of the word just written: first mismatch address is kept
        step = 1'b1;
        state_d = last ? IDLE : WR;
        done_d = last;
        err_flag_d = err_flag_q | mismatch;
        err_addr_d = !err_flag_q && mismatch ? ram_addr_q : err_addr_q;
      end else begin
        rd_data_d = bus.ram_dataOut;
        rd_valid_d = 1'b1;
        rd_last_d = last;
        state_d = RD_HOLD;
      end
      RD_HOLD: if (bus.rd_ready) begin
        rd_valid_d = 1'b0;
        rd_last_d = 1'b0;
        step = 1'b1;
        state_d = last ? IDLE : RD_ISSUE;
        done_d = last;
        ram_addr_d = addr_nxt;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vfy_q <= 1'b0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
      done_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vfy_q <= vfy_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q <= ram_din_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
      done_q <= done_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.wd_ready = state_q == WR;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last = rd_last_q;
  assign bus.rd_data = rd_data_q;
  assign bus.err_flag = err_flag_q;
  assign bus.err_addr = err_addr_q;
  assign bus.ram_we = ram_we_q;
  assign bus.ram_address = ram_addr_q;
  assign bus.ram_dataIn = ram_din_q;
endmodule
